// File: rtl/btn_step_counter.sv
// btn_step_counter
//
// Up/down counter driven by debounced push buttons. Each new press gives one
// step. A button that stays held auto-repeats, first after REPEAT_DELAY cycles
// and then every REPEAT_PERIOD cycles. The clear button forces the count to
// zero. Counting wraps between MAX_COUNT and 0.
//
// Ports:
//   clk      - single clock, all logic on its rising edge
//   rst      - synchronous, active-high reset
//   up_btn   - debounced up button level, 1 = pressed
//   down_btn - debounced down button level, 1 = pressed
//   clr_btn  - debounced clear button level, 1 = pressed
//   count    - registered count value, WIDTH bits
//   step     - one-cycle strobe following each up/down count change
//   wrap     - one-cycle strobe, together with step, when the step wrapped
module btn_step_counter #(
  parameter int WIDTH         = 8,
  parameter int MAX_COUNT     = 255,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_btn,
  input  logic             down_btn,
  input  logic             clr_btn,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0]    DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0] MAX_VAL     = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          dir;
  logic          up_q;
  logic          down_q;

  logic             up_rise;
  logic             down_rise;
  logic             held;
  logic             opposite;
  logic             abort;
  logic             step_up;
  logic             up_wrap;
  logic             down_wrap;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] down_next;
  logic [WIDTH-1:0] sel_count;
  logic             sel_wrap;

  assign up_rise   = up_btn & ~up_q;
  assign down_rise = down_btn & ~down_q;

  // While repeating, leave on release of the held button or on any press of
  // the other one.
  assign held     = dir ? up_btn : down_btn;
  assign opposite = dir ? down_btn : up_btn;
  assign abort    = ~held | opposite;

  // In IDLE the step direction comes from which button rose; otherwise it is
  // the latched direction.
  assign step_up = (state == IDLE) ? up_rise : dir;

  assign up_wrap   = (count == MAX_VAL);
  assign up_next   = up_wrap ? '0 : count + WIDTH'(1);
  assign down_wrap = (count == '0);
  assign down_next = down_wrap ? MAX_VAL : count - WIDTH'(1);
  assign sel_count = step_up ? up_next : down_next;
  assign sel_wrap  = step_up ? up_wrap : down_wrap;

  // Edge-detect registers, press/repeat FSM and the registered outputs. The
  // edge registers keep following the buttons through reset and clear, so a
  // button held across either one never produces a step.
  always_ff @(posedge clk) begin
    up_q   <= up_btn;
    down_q <= down_btn;
    step   <= 1'b0;
    wrap   <= 1'b0;
    if (rst) begin
      count <= '0;
      state <= IDLE;
      timer <= '0;
      dir   <= 1'b0;
    end else if (clr_btn) begin
      count <= '0;
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((up_rise && !down_btn) || (down_rise && !up_btn)) begin
            count <= sel_count;
            step  <= 1'b1;
            wrap  <= sel_wrap;
            dir   <= up_rise;
            timer <= '0;
            state <= DELAY;
          end
        end
        DELAY: begin
          if (abort) begin
            timer <= '0;
            state <= IDLE;
          end else if (timer == DELAY_LAST) begin
            count <= sel_count;
            step  <= 1'b1;
            wrap  <= sel_wrap;
            timer <= '0;
            state <= REPEAT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          if (abort) begin
            timer <= '0;
            state <= IDLE;
          end else if (timer == PERIOD_LAST) begin
            count <= sel_count;
            step  <= 1'b1;
            wrap  <= sel_wrap;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_step_counter.sv
// Self-checking bench for btn_step_counter with WIDTH=4, MAX_COUNT=9,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. Inputs change 1 time unit after each rising
// edge and outputs are sampled at that same point, so every check sees the
// result of the edge just taken.
module tb_btn_step_counter;

  logic       clk;
  logic       rst;
  logic       up_btn;
  logic       down_btn;
  logic       clr_btn;
  logic [3:0] count;
  logic       step;
  logic       wrap;

  int vectors;
  int miscompares;
  int step_total;
  int wrap_total;
  int step_base;

  btn_step_counter #(
    .WIDTH        (4),
    .MAX_COUNT    (9),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_btn  (up_btn),
    .down_btn(down_btn),
    .clr_btn (clr_btn),
    .count   (count),
    .step    (step),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive the buttons and run n clock edges, tallying step and wrap pulses.
  task automatic applyStimulus(input logic u, input logic d, input logic c, input int n);
    up_btn   = u;
    down_btn = d;
    clr_btn  = c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      step_total += int'(step);
      wrap_total += int'(wrap);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    step_total  = 0;
    wrap_total  = 0;
    rst         = 1'b1;
    up_btn      = 1'b1;
    down_btn    = 1'b0;
    clr_btn     = 1'b0;

    // Reset with up held, then release reset while up is still held.
    applyStimulus(1, 0, 0, 3);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_step", step, 0);
    checkOutput("rst_wrap", wrap, 0);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 5);
    checkOutput("held_rst_count", count, 0);
    checkOutput("held_rst_steps", step_total, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("repress_count", count, 1);
    checkOutput("repress_step", step, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("repress_step_low", step, 0);

    // Five up presses then three down presses, 2 cycles each.
    applyStimulus(0, 0, 1, 1);
    checkOutput("clr_count", count, 0);
    applyStimulus(0, 0, 0, 1);
    step_total = 0;
    wrap_total = 0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 0, 0, 2);
      checkOutput("up_press", count, i);
      applyStimulus(0, 0, 0, 1);
    end
    for (int i = 4; i >= 2; i--) begin
      applyStimulus(0, 1, 0, 2);
      checkOutput("down_press", count, i);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("press_steps", step_total, 8);
    checkOutput("press_wraps", wrap_total, 0);

    // Wrap in both directions.
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("wrap_dn_count", count, 9);
    checkOutput("wrap_dn_step", step, 1);
    checkOutput("wrap_dn_wrap", wrap, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_pulse_low", wrap, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("wrap_up_count", count, 0);
    checkOutput("wrap_up_step", step, 1);
    checkOutput("wrap_up_wrap", wrap, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("wrap_dn2_count", count, 9);
    checkOutput("wrap_dn2_wrap", wrap, 1);
    applyStimulus(0, 0, 0, 1);

    // Hold up for 20 edges: steps at edges 0, 8, 12, 16.
    applyStimulus(0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 1);
      checkOutput("hold_step", step, (i == 0 || i == 8 || i == 12 || i == 16) ? 1 : 0);
    end
    checkOutput("hold20_count", count, 4);
    applyStimulus(0, 0, 0, 1);

    // Release before edge 15 instead: steps at 0, 8, 12.
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 0, 0, 15);
    applyStimulus(0, 0, 0, 1);
    checkOutput("hold15_count", count, 3);
    checkOutput("hold15_step", step, 0);

    // Down asserted at edge 5 while up held stops repeating.
    applyStimulus(0, 0, 1, 1);
    step_base = step_total;
    applyStimulus(1, 0, 0, 5);
    applyStimulus(1, 1, 0, 15);
    checkOutput("opp_count", count, 1);
    checkOutput("opp_steps", step_total - step_base, 1);
    applyStimulus(1, 0, 0, 10);
    checkOutput("opp_release_count", count, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("opp_repress_count", count, 2);
    applyStimulus(0, 0, 0, 1);

    // Reset landing on the first auto-repeat edge drops that step.
    applyStimulus(0, 0, 1, 1);
    applyStimulus(1, 0, 0, 8);
    checkOutput("pre_rst_count", count, 1);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 1);
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_step", step, 0);
    rst = 1'b0;
    step_base = step_total;
    applyStimulus(1, 0, 0, 12);
    checkOutput("post_rst_steps", step_total - step_base, 0);
    applyStimulus(0, 0, 0, 1);

    // Clear overrides a simultaneous up rise; up held across clear release.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("six_count", count, 6);
    step_base = step_total;
    applyStimulus(1, 0, 1, 1);
    checkOutput("clr_rise_count", count, 0);
    checkOutput("clr_rise_step", step, 0);
    applyStimulus(1, 0, 1, 2);
    applyStimulus(1, 0, 0, 12);
    checkOutput("clr_held_count", count, 0);
    checkOutput("clr_held_steps", step_total - step_base, 0);
    applyStimulus(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_step_counter.md
# btn_step_counter

Steps a WIDTH-bit count up or down in response to debounced push-button levels. It sits directly downstream of the button debouncers and shares their clock. A single press produces exactly one step. Holding a button auto-repeats after an initial delay. A clear button forces the count to zero. The count feeds the display driver, and one-cycle step and wrap strobes are provided for downstream logic.

## Interface
- WIDTH, 8: count width in bits.
- MAX_COUNT, 255: highest count value, ≤ 2^WIDTH−1. Counting wraps between MAX_COUNT and 0.
- REPEAT_DELAY, 50_000_000: cycles from the initial step to the first auto-repeat step. Must be ≥ 2.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat steps. Must be ≥ 2.
- clk  input  1: the single clock. All logic is on its rising edge.
- rst  input  1: synchronous, active-high reset.
- up_btn  input  1: debounced level, synchronous to clk. 1 = pressed.
- down_btn  input  1: debounced level, synchronous to clk.
- clr_btn  input  1: debounced level, synchronous to clk.
- count  output  WIDTH: current count, registered.
- step  output  1: one-cycle strobe, high in the cycle after each count change caused by up or down.
- wrap  output  1: one-cycle strobe, high together with step when the step crossed MAX_COUNT↔0.

## Operation
- Edge detection: previous-level registers up_q and down_q. A rise means btn=1 and btn_q=0.
- During rst, up_q and down_q load the current button levels. A button held through reset release therefore causes no step.
- FSM states: IDLE, DELAY, REPEAT. A dir register holds 1 for up and 0 for down. Timer width is ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)))+1.
- IDLE:
  - A rise on exactly one button with the other button low: step once in that direction, latch dir, timer←0, go to DELAY.
  - Rises on both buttons, or a rise while the other button is held: no step, stay in IDLE.
- DELAY: timer increments each cycle. When timer = REPEAT_DELAY−1: step, timer←0, go to REPEAT.
- REPEAT: when timer = REPEAT_PERIOD−1: step, timer←0.
- DELAY and REPEAT exits: if the held button is released, or the opposite button becomes high, go to IDLE with no step and timer←0. This check has priority over the timer-expiry step in the same cycle. A button still held after the exit gives no step until it is released and pressed again.
- Up step: count = MAX_COUNT → 0 with wrap=1, otherwise count+1.
- Down step: count = 0 → MAX_COUNT with wrap=1, otherwise count−1.
- clr_btn=1:
  - count←0, FSM←IDLE, timer←0. No step or wrap pulse.
  - Overrides any simultaneous rise or timer expiry.
  - up_q and down_q keep tracking the inputs. A button held across the clear release therefore gives no step.
- Reset during any state:
  - Outputs: count=0, step=0, wrap=0.
  - Internal: FSM=IDLE, timer=0.
  - A step that would occur on the same edge is dropped.

## Timing
- The rising edge that first samples a button at 1 with btn_q=0 updates count. step and wrap are high for exactly the following cycle.
- Held button pressed at edge N: steps at edges N, N+REPEAT_DELAY, N+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- clr_btn sampled high at edge N: count=0 after edge N.
- Outputs are registered, with no combinational path from input to output.

## Test plan
All scenarios use WIDTH=4, MAX_COUNT=9, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Reset held 3 cycles with up_btn=1, then released with up_btn still 1 → count stays 0, step never asserts. Releasing and re-pressing up → count=1, one step pulse.
- Five single up presses of 2 cycles each, then three down presses → count goes 1..5, then 4, 3, 2. Exactly 8 step pulses, wrap never asserts.
- From count=9 press up → count=0 with step=wrap=1 for one cycle. Press down → count=9 with wrap=1.
- Hold up for 20 cycles from count=0 → steps at cycles 0, 8, 12, 16, final count=4. Release at cycle 15 instead → count=3.
- Holding up, assert down at cycle 5 → no further steps. Release down while up is held → no step until up is re-pressed.
- Count=6, clr_btn and an up rise on the same edge → count=0, step=0. With up held during clr, releasing clr gives no step.
